// File: rtl/std_out_pkg.sv
// Shared constants and TX state encoding for the stdOut UART transmitter.
// Imported by the word FIFO and the transmitter top.
package std_out_pkg;
    localparam int STD_OUT_WORD_WIDTH = 32;
    localparam int BYTES_PER_WORD     = 4;
    localparam int UART_DATA_BITS     = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;
endpackage

// File: rtl/std_out_fifo.sv
// Synchronous word FIFO with pointer-difference occupancy.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module std_out_fifo
    import std_out_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  logic [STD_OUT_WORD_WIDTH-1:0] i_data,
    output logic [STD_OUT_WORD_WIDTH-1:0] o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [FIFO_DEPTH_LOG2:0]      o_count
);
    localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2 + 1;

    logic [STD_OUT_WORD_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]                 r_wr_ptr;
    logic [PW-1:0]                 r_rd_ptr;
    logic                          w_do_push;
    logic                          w_do_pop;

    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_empty   = (o_count == '0);
    assign o_full    = (o_count == PW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[FIFO_DEPTH_LOG2-1:0]];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= i_data;
    end
endmodule

// File: rtl/std_out_uart_tx.sv
// stdOut word sink: ready/ack capture into a FIFO, then 8N1 serialisation
// of each word as four bytes, least-significant byte first.
module std_out_uart_tx
    import std_out_pkg::*;
#(
    parameter int CLOCK_DIVIDER   = 868,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                          clockInput,
    input  logic                          resetInput,
    input  logic                          stdOutReadyInput,
    input  logic [STD_OUT_WORD_WIDTH-1:0] stdOutDataInput,
    output logic                          stdOutAckOutput,
    output logic                          uartTxOutput,
    output logic                          busyOutput
);
    localparam int BAUD_W = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
    localparam int BIT_W  = $clog2(UART_DATA_BITS);
    localparam int BYTE_W = $clog2(BYTES_PER_WORD);
    localparam int CW     = FIFO_DEPTH_LOG2 + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCK_DIVIDER - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES_PER_WORD - 1);

    tx_state_e                     r_state;
    logic [STD_OUT_WORD_WIDTH-1:0] r_shift;
    logic [BAUD_W-1:0]             r_baud;
    logic [BIT_W-1:0]              r_bit_idx;
    logic [BYTE_W-1:0]             r_byte_idx;
    logic                          r_ack;
    logic                          r_tx;
    logic                          r_busy;

    logic                          w_push;
    logic                          w_pop;
    logic                          w_full;
    logic                          w_empty;
    logic                          w_tick;
    logic                          w_word_done;
    logic                          w_idle_next;
    logic [STD_OUT_WORD_WIDTH-1:0] w_fifo_data;
    logic [CW-1:0]                 w_count;
    logic [CW-1:0]                 w_count_next;

    assign w_tick       = (r_baud == BAUD_LAST);
    assign w_word_done  = (r_state == TX_STOP) && w_tick
                          && (r_byte_idx == BYTE_LAST);
    assign w_pop        = !w_empty && ((r_state == TX_IDLE) || w_word_done);
    // Full is judged after this edge's pop, so a draining FIFO still accepts.
    assign w_push       = stdOutReadyInput && !r_ack && (!w_full || w_pop);
    assign w_idle_next  = w_empty && ((r_state == TX_IDLE) || w_word_done);
    assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);

    std_out_fifo #(
        .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
    ) u_fifo (
        .i_clk   (clockInput),
        .i_rst_n (resetInput),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (stdOutDataInput),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clockInput) begin
        if (!resetInput) begin
            r_ack  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_ack  <= w_push;
            r_busy <= (w_count_next != '0) || !w_idle_next;
        end
    end

    always_ff @(posedge clockInput) begin
        if (!resetInput) begin
            r_state    <= TX_IDLE;
            r_tx       <= 1'b1;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
        end else begin
            r_baud <= (r_state == TX_IDLE || w_tick) ? '0 : r_baud + 1'b1;
            unique case (r_state)
                TX_IDLE: begin
                    if (w_pop) begin
                        r_shift    <= w_fifo_data;
                        r_byte_idx <= '0;
                        r_tx       <= 1'b0;
                        r_state    <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_tick) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
                        r_state   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == BIT_LAST) begin
                            r_tx    <= 1'b1;
                            r_state <= TX_STOP;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                TX_STOP: begin
                    if (w_tick) begin
                        if (r_byte_idx != BYTE_LAST) begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_tx       <= 1'b0;
                            r_state    <= TX_START;
                        end else if (w_pop) begin
                            r_shift    <= w_fifo_data;
                            r_byte_idx <= '0;
                            r_tx       <= 1'b0;
                            r_state    <= TX_START;
                        end else begin
                            r_state <= TX_IDLE;
                        end
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign stdOutAckOutput = r_ack;
    assign uartTxOutput    = r_tx;
    assign busyOutput      = r_busy;
endmodule

// File: tb/tb_std_out_uart_tx.sv
// Bench for std_out_uart_tx: a UART receiver decodes the line and the
// decoded bytes are compared with bytes derived from the words sent.
module tb_std_out_uart_tx;
    localparam int CD  = 4;
    localparam int FL2 = 2;

    typedef struct {
        logic [31:0] word;
        bit          hold;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] data  = '0;
    logic        ack;
    logic        tx;
    logic        busy;

    std_out_uart_tx #(
        .CLOCK_DIVIDER   (CD),
        .FIFO_DEPTH_LOG2 (FL2)
    ) dut (
        .clockInput       (clk),
        .resetInput       (rst_n),
        .stdOutReadyInput (ready),
        .stdOutDataInput  (data),
        .stdOutAckOutput  (ack),
        .uartTxOutput     (tx),
        .busyOutput       (busy)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   rst_cnt = 0;
    int   ack_cnt = 0;
    int   dbl_ack = 0;
    int   words_sent = 0;
    int   ferr = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_ack = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         fs_q[$];

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) rst_cnt++;
    end

    always @(negedge clk) begin
        if (ack === 1'b1) begin
            ack_cnt++;
            if (prev_ack === 1'b1) dbl_ack++;
        end
        prev_ack = ack;
    end

    // Line receiver: sample mid-bit, drop any frame overlapped by reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                automatic int         r0  = rst_cnt;
                automatic int         st  = cyc;
                automatic logic [7:0] b   = '0;
                automatic bit         bad = 1'b0;
                repeat (CD / 2) @(negedge clk);
                if (tx !== 1'b0) bad = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    repeat (CD) @(negedge clk);
                    b[k] = tx;
                end
                repeat (CD) @(negedge clk);
                if (tx !== 1'b1) bad = 1'b1;
                repeat (CD - CD / 2 - 1) @(negedge clk);
                if (rst_cnt == r0) begin
                    if (bad) ferr++;
                    rx_q.push_back(b);
                    fs_q.push_back(st);
                end
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] w, input bit hold, input bit keep,
                        input bit model, output int ac);
        bit got = 1'b0;
        ready = 1'b1;
        data  = w;
        for (int t = 0; t < 1000 && !got; t++) begin
            @(negedge clk);
            if (ack === 1'b1) got = 1'b1;
        end
        ac = cyc;
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL ack wait %0h: got no ack expected ack", w);
        end
        words_sent++;
        if (model)
            for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
        if (hold) @(negedge clk);
        if (!keep) ready = 1'b0;
    endtask

    task automatic drain(input string nm, input bit gaps);
        int t = 0;
        int n;
        int budget;
        budget = exp_q.size() * 10 * CD + 200;
        while (rx_q.size() < exp_q.size() && t < budget) begin
            @(negedge clk);
            t++;
        end
        repeat (12 * CD) @(negedge clk);
        chk($sformatf("%s nbytes", nm), rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s byte%0d", nm, i), rx_q[i], exp_q[i]);
        if (gaps)
            for (int i = 1; i < fs_q.size(); i++)
                chk($sformatf("%s gap%0d", nm, i), fs_q[i] - fs_q[i-1],
                    10 * CD);
        chk($sformatf("%s busy end", nm), busy, 1'b0);
        rx_q.delete();
        exp_q.delete();
        fs_q.delete();
    endtask

    initial begin
        vec_t        tbl[4];
        logic [31:0] fw[6];
        int          a[6];
        int          ac;
        int          acks0;
        int          target;
        bit          ok;

        tbl[0] = '{32'h00000041, 1'b0, 8'h41, 8'h00, 8'h00, 8'h00};
        tbl[1] = '{32'hA1B2C3D4, 1'b0, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
        tbl[2] = '{32'h12345678, 1'b1, 8'h78, 8'h56, 8'h34, 8'h12};
        tbl[3] = '{32'hFF00807F, 1'b1, 8'h7F, 8'h80, 8'h00, 8'hFF};
        fw = '{32'h03020100, 32'h13121110, 32'h23222120,
               32'h33323130, 32'h43424140, 32'h53525150};

        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset line", tx, 1'b1);
        chk("reset ack", ack, 1'b0);
        chk("reset busy", busy, 1'b0);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || ack !== 1'b0) ok = 1'b0;
        end
        chk("quiet after reset", ok, 1'b1);

        for (int i = 0; i < 4; i++) begin
            send(tbl[i].word, tbl[i].hold, 1'b0, 1'b0, ac);
            exp_q.push_back(tbl[i].b0);
            exp_q.push_back(tbl[i].b1);
            exp_q.push_back(tbl[i].b2);
            exp_q.push_back(tbl[i].b3);
            if (i == 0) begin
                chk("ack cycle line", tx, 1'b1);
                chk("ack cycle busy", busy, 1'b1);
                @(negedge clk);
                chk("start latency", tx, 1'b0);
                repeat (40 * CD - 1) @(negedge clk);
                chk("busy last stop", busy, 1'b1);
                @(negedge clk);
                chk("busy after word", busy, 1'b0);
                chk("line after word", tx, 1'b1);
            end
            drain($sformatf("vec%0d", i), 1'b1);
        end

        for (int i = 0; i < 6; i++)
            send(fw[i], 1'b0, (i < 5), 1'b1, a[i]);
        chk("accept rate", a[1] - a[0], 2);
        chk("fill fifo", a[4] - a[0], 8);
        chk("full stall", a[5] - a[0], 40 * CD + 1);
        drain("fifo", 1'b1);

        acks0 = ack_cnt;
        for (int i = 0; i < 3; i++) begin
            send($urandom, 1'b1, 1'b0, 1'b1, ac);
            @(negedge clk);
        end
        chk("held ready acks", ack_cnt - acks0, 3);
        drain("hold", 1'b1);

        for (int i = 0; i < 10; i++) begin
            send($urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b1, ac);
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        drain("random", 1'b0);

        send(32'h5500F0A5, 1'b0, 1'b0, 1'b0, ac);
        send(32'hDEADBEEF, 1'b0, 1'b0, 1'b0, target);
        target = ac + 1 + 14 * CD + 1;
        while (cyc < target) @(negedge clk);
        chk("pre-reset bit3", tx, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset mid line", tx, 1'b1);
        chk("reset mid busy", busy, 1'b0);
        chk("reset mid ack", ack, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        chk("fifo flushed", ok, 1'b1);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        send(32'h0000005A, 1'b0, 1'b0, 1'b1, ac);
        drain("post reset", 1'b0);

        chk("ack count", ack_cnt, words_sent);
        chk("ack single pulse", dbl_ack, 0);
        chk("framing", ferr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
